// File: rtl/hwpf_addr_buffer_if.sv
// Candidate-buffer port bundle: control and push/pop requests in, candidate and status out.
// The master side is the prefetch engine. The slave side is the buffer.
interface hwpf_addr_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 40
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              flush_i;
    logic              lock_i;
    logic              push_i;
    logic [ADDR_W-1:0] val_i;
    logic              pop_i;
    logic              valid_o;
    logic [ADDR_W-1:0] req_o;
    logic [CNT_W-1:0]  count_o;
    logic              full_o;
    logic              drop_o;
    logic              dup_o;

    modport master (
        output flush_i, lock_i, push_i, val_i, pop_i,
        input  valid_o, req_o, count_o, full_o, drop_o, dup_o
    );

    modport slave (
        input  flush_i, lock_i, push_i, val_i, pop_i,
        output valid_o, req_o, count_o, full_o, drop_o, dup_o
    );
endinterface

// File: rtl/hwpf_addr_buffer.sv
// Prefetch-candidate address buffer. It works as a LIFO or a FIFO and has optional duplicate rejection.
// Latency: req_o is combinational from registered state. drop_o and dup_o are registered one-cycle pulses.
// Backpressure: none. A push when full overwrites the oldest entry and reports it on drop_o.
module hwpf_addr_buffer #(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 40,
    parameter int MODE     = 0,
    parameter int DEDUP_EN = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hwpf_addr_buffer_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    logic [ADDR_W-1:0] mem_q [DEPTH];
    ptr_t              head_q, head_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drop_q, drop_d;
    logic              dup_q, dup_d;
    logic              wr_en;
    ptr_t              wr_ptr;
    logic              hit;
    logic              empty, full;
    ptr_t              next_ptr, newest_ptr, rd_ptr;

    // The inputs are always below 2*DEPTH, so one conditional subtract is enough.
    // This keeps the wrap correct when DEPTH is not a power of two.
    function automatic ptr_t ptr_add(input ptr_t p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s -= DEPTH;
        return ptr_t'(s);
    endfunction

    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign next_ptr   = ptr_add(head_q, int'(count_q));
    assign newest_ptr = ptr_add(next_ptr, DEPTH - 1);
    assign rd_ptr     = (MODE == 0) ? newest_ptr : head_q;

    // Only slots inside the window [head, head+count) take part in the compare.
    // Stale contents outside that window are ignored.
    always_comb begin
        int off;
        hit = 1'b0;
        off = 0;
        for (int i = 0; i < DEPTH; i++) begin
            off = (i >= int'(head_q)) ? (i - int'(head_q)) : (i + DEPTH - int'(head_q));
            if ((DEDUP_EN != 0) && (off < int'(count_q)) && (mem_q[i] == bus.val_i))
                hit = 1'b1;
        end
    end

    always_comb begin
        logic push_acc;
        logic do_pop;
        head_d   = head_q;
        count_d  = count_q;
        drop_d   = 1'b0;
        dup_d    = 1'b0;
        wr_en    = 1'b0;
        wr_ptr   = next_ptr;
        push_acc = bus.push_i && !hit;
        do_pop   = bus.pop_i && !empty;
        if (bus.flush_i) begin
            head_d  = '0;
            count_d = '0;
        end else if (!bus.lock_i) begin
            dup_d = bus.push_i && hit;
            if (push_acc && do_pop) begin
                wr_en = 1'b1;
                if (MODE == 0) begin
                    wr_ptr = newest_ptr;
                end else begin
                    // When the buffer is full, next_ptr equals head, which is the slot freed by the pop.
                    wr_ptr = next_ptr;
                    head_d = ptr_add(head_q, 1);
                end
            end else if (push_acc) begin
                wr_en = 1'b1;
                if (full) begin
                    wr_ptr = head_q;
                    head_d = ptr_add(head_q, 1);
                    drop_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else if (do_pop) begin
                count_d = count_q - CNT_W'(1);
                if (MODE != 0) head_d = ptr_add(head_q, 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            dup_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            dup_q   <= dup_d;
            if (wr_en) mem_q[wr_ptr] <= bus.val_i;
        end
    end

    assign bus.valid_o = !empty;
    assign bus.req_o   = empty ? '0 : mem_q[rd_ptr];
    assign bus.count_o = count_q;
    assign bus.full_o  = full;
    assign bus.drop_o  = drop_q;
    assign bus.dup_o   = dup_q;
endmodule

// File: tb/tb_hwpf_addr_buffer.sv
// Directed vector bench for hwpf_addr_buffer. It drives one LIFO instance and one FIFO instance, each with DEPTH=4.
module tb_hwpf_addr_buffer;
    localparam int AW = 40;

    typedef struct {
        bit          sel;
        bit          rst, flush, lock, push, pop;
        logic [39:0] val;
        bit          e_valid;
        logic [39:0] e_req;
        logic [2:0]  e_count;
        bit          e_full, e_drop, e_dup;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_l, rst_f;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    hwpf_addr_buffer_if #(.DEPTH(4), .ADDR_W(AW)) if_l ();
    hwpf_addr_buffer_if #(.DEPTH(4), .ADDR_W(AW)) if_f ();

    hwpf_addr_buffer #(.DEPTH(4), .ADDR_W(AW), .MODE(0), .DEDUP_EN(1)) u_lifo (
        .clk_i(clk_i), .rst_i(rst_l), .bus(if_l)
    );
    hwpf_addr_buffer #(.DEPTH(4), .ADDR_W(AW), .MODE(1), .DEDUP_EN(1)) u_fifo (
        .clk_i(clk_i), .rst_i(rst_f), .bus(if_f)
    );

    task automatic cmp(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk_i);
        {rst_l, if_l.flush_i, if_l.lock_i, if_l.push_i, if_l.pop_i} = '0;
        {rst_f, if_f.flush_i, if_f.lock_i, if_f.push_i, if_f.pop_i} = '0;
        if_l.val_i = v.val;
        if_f.val_i = v.val;
        if (v.sel == 1'b0) {rst_l, if_l.flush_i, if_l.lock_i, if_l.push_i, if_l.pop_i} = {v.rst, v.flush, v.lock, v.push, v.pop};
        else               {rst_f, if_f.flush_i, if_f.lock_i, if_f.push_i, if_f.pop_i} = {v.rst, v.flush, v.lock, v.push, v.pop};
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outs(input bit sel, input int idx, input vec_t v);
        if (sel == 1'b0) begin
            cmp("lifo.valid", idx, 64'(if_l.valid_o), 64'(v.e_valid));
            cmp("lifo.req",   idx, 64'(if_l.req_o),   64'(v.e_req));
            cmp("lifo.count", idx, 64'(if_l.count_o), 64'(v.e_count));
            cmp("lifo.full",  idx, 64'(if_l.full_o),  64'(v.e_full));
            cmp("lifo.drop",  idx, 64'(if_l.drop_o),  64'(v.e_drop));
            cmp("lifo.dup",   idx, 64'(if_l.dup_o),   64'(v.e_dup));
        end else begin
            cmp("fifo.valid", idx, 64'(if_f.valid_o), 64'(v.e_valid));
            cmp("fifo.req",   idx, 64'(if_f.req_o),   64'(v.e_req));
            cmp("fifo.count", idx, 64'(if_f.count_o), 64'(v.e_count));
            cmp("fifo.full",  idx, 64'(if_f.full_o),  64'(v.e_full));
            cmp("fifo.drop",  idx, 64'(if_f.drop_o),  64'(v.e_drop));
            cmp("fifo.dup",   idx, 64'(if_f.dup_o),   64'(v.e_dup));
        end
    endtask

    initial begin
        vec_t h;
        // Field order: sel, rst, flush, lock, push, pop, val | valid, req, count, full, drop, dup
        // LIFO: idle after reset, fill, overflow, then drain
        vecs.push_back('{0,0,0,0,0,0,'h0,   0,'h0,  0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0,'h0,   0,'h0,  0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0,'h0,   0,'h0,  0,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h10,  1,'h10, 1,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h20,  1,'h20, 2,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h30,  1,'h30, 3,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h40,  1,'h40, 4,1,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h50,  1,'h50, 4,1,1,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   1,'h40, 3,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   1,'h30, 2,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   1,'h20, 1,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   0,'h0,  0,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   0,'h0,  0,0,0,0});
        // LIFO: a simultaneous push and pop replaces the newest entry
        vecs.push_back('{0,0,0,0,1,0,'hA,   1,'hA,  1,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'hB,   1,'hB,  2,0,0,0});
        vecs.push_back('{0,0,0,0,1,1,'hC,   1,'hC,  2,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   1,'hA,  1,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   0,'h0,  0,0,0,0});
        // LIFO: duplicate rejection, with and without a pop in the same cycle, and a stale slot ignored
        vecs.push_back('{0,0,0,0,1,0,'h100, 1,'h100,1,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h200, 1,'h200,2,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h100, 1,'h200,2,0,0,1});
        vecs.push_back('{0,0,0,0,0,0,'h0,   1,'h200,2,0,0,0});
        vecs.push_back('{0,0,0,0,1,1,'h100, 1,'h100,1,0,0,1});
        vecs.push_back('{0,0,0,0,1,0,'h200, 1,'h200,2,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   1,'h100,1,0,0,0});
        vecs.push_back('{0,0,0,0,0,1,'h0,   0,'h0,  0,0,0,0});
        vecs.push_back('{0,0,0,0,1,1,'h7,   1,'h7,  1,0,0,0});
        // LIFO: control priority of lock, flush and reset
        vecs.push_back('{0,0,0,0,1,0,'h8,   1,'h8,  2,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h9,   1,'h9,  3,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h8,   1,'h9,  3,0,0,1});
        vecs.push_back('{0,0,0,1,1,1,'hA,   1,'h9,  3,0,0,0});
        vecs.push_back('{0,0,0,1,1,1,'hA,   1,'h9,  3,0,0,0});
        vecs.push_back('{0,0,1,1,1,0,'hA,   0,'h0,  0,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h11,  1,'h11, 1,0,0,0});
        vecs.push_back('{0,0,0,0,1,0,'h12,  1,'h12, 2,0,0,0});
        vecs.push_back('{0,1,0,0,1,0,'h13,  0,'h0,  0,0,0,0});
        vecs.push_back('{0,0,0,0,0,0,'h0,   0,'h0,  0,0,0,0});
        // FIFO: order with pointer wrap
        vecs.push_back('{1,0,0,0,0,0,'h0,   0,'h0,  0,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h1,   1,'h1,  1,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h2,   1,'h1,  2,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h3,   1,'h1,  3,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h4,   1,'h1,  4,1,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h2,  3,0,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h3,  2,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h5,   1,'h3,  3,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h6,   1,'h3,  4,1,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h4,  3,0,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h5,  2,0,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h6,  1,0,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   0,'h0,  0,0,0,0});
        // FIFO: a push and pop while full reuses the freed slot; a push alone while full drops the oldest
        vecs.push_back('{1,0,0,0,1,0,'h1,   1,'h1,  1,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h2,   1,'h1,  2,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h3,   1,'h1,  3,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h4,   1,'h1,  4,1,0,0});
        vecs.push_back('{1,0,0,0,1,1,'h5,   1,'h2,  4,1,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h6,   1,'h3,  4,1,1,0});
        vecs.push_back('{1,0,0,0,0,0,'h0,   1,'h3,  4,1,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h4,  3,0,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h5,  2,0,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   1,'h6,  1,0,0,0});
        vecs.push_back('{1,0,0,0,0,1,'h0,   0,'h0,  0,0,0,0});
        vecs.push_back('{1,0,0,0,1,1,'h7,   1,'h7,  1,0,0,0});
        vecs.push_back('{1,0,0,0,1,0,'h7,   1,'h7,  1,0,0,1});

        {if_l.flush_i, if_l.lock_i, if_l.push_i, if_l.pop_i} = '0;
        {if_f.flush_i, if_f.lock_i, if_f.push_i, if_f.pop_i} = '0;
        if_l.val_i = '0;
        if_f.val_i = '0;
        rst_l = 1'b1;
        rst_f = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_outs(0, -1, '{0,0,0,0,0,0,'h0, 0,'h0,0,0,0,0});
        check_outs(1, -1, '{1,0,0,0,0,0,'h0, 0,'h0,0,0,0,0});

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check_outs(vecs[i].sel, i, vecs[i]);
        end

        // FIFO state is {7}. Fill it, overflow it, then hold lock across pushes.
        // Expect one drop pulse and then frozen state.
        h = '{1,0,0,0,1,0,'h8, 1,'h7,2,0,0,0};
        drive(h); check_outs(1, 100, h);
        h.val = 'h9;  h.e_count = 3; drive(h); check_outs(1, 101, h);
        h.val = 'hA;  h.e_count = 4; h.e_full = 1; drive(h); check_outs(1, 102, h);
        h.val = 'h11; h.e_req = 'h8; h.e_drop = 1; drive(h); check_outs(1, 103, h);
        for (int k = 0; k < 3; k++) begin
            h = '{1,0,0,1,1,1,'h12, 1,'h8,4,1,0,0};
            drive(h);
            check_outs(1, 104 + k, h);
        end
        h = '{1,0,1,0,1,1,'h13, 0,'h0,0,0,0,0};
        drive(h); check_outs(1, 107, h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hwpf_addr_buffer.md
Name: hwpf_addr_buffer

Overview:
Parametrised prefetch-candidate address buffer for the Sargantana hardware prefetcher.
It holds up to DEPTH line addresses that the prefetch engine generates, and offers one candidate per cycle to the request emitter.
It is selectable at elaboration time as LIFO (newest candidate first, stack mode) or FIFO (oldest first, queue mode).
When full it drops the oldest entry, can optionally reject duplicate addresses, and reports occupancy and drop/duplicate events to the prefetcher control logic.

Parameters:
DEPTH, 8, number of entries; any value >= 2, power of two not required.
ADDR_W, 40, width of a stored address in bits.
MODE, 0, 0 = LIFO (output newest), 1 = FIFO (output oldest).
DEDUP_EN, 1, 1 = a push whose address matches any valid entry is discarded.
CNT_W, $clog2(DEPTH+1), width of count_o (derived; not to be overridden).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  synchronous active-high reset.
flush_i  input  1  empties the buffer on the next edge.
lock_i  input  1  freezes all state; push_i and pop_i are ignored.
push_i  input  1  write val_i as the newest entry.
val_i  input  ADDR_W  address to push.
pop_i  input  1  consume the entry currently on req_o.
valid_o  output  1  buffer is not empty.
req_o  output  ADDR_W  current candidate; 0 when empty.
count_o  output  CNT_W  number of valid entries, 0..DEPTH.
full_o  output  1  count_o == DEPTH.
drop_o  output  1  one-cycle pulse: the oldest entry was overwritten on the previous edge.
dup_o  output  1  one-cycle pulse: a push was discarded as a duplicate on the previous edge.

Behaviour:
- Reset and idle state:
  - Reset (rst_i high at the edge): count = 0, head = 0, all entries cleared to 0.
  - After reset: valid_o = 0, req_o = 0, count_o = 0, full_o = 0, drop_o = 0, dup_o = 0.
  - Reset wins over flush_i and lock_i, and may assert mid-operation.
- Priority: rst_i > flush_i > lock_i > normal operation.
- Flush: count = 0 and head = 0. Entry contents need not be cleared. drop_o and dup_o are 0 in the following cycle.
- Lock: all state holds. drop_o and dup_o are 0 in the following cycle.
- Storage:
  - Circular array with head pointing at the oldest entry.
  - Newest entry is at (head + count - 1) mod DEPTH. Next write slot is (head + count) mod DEPTH.
  - All pointer arithmetic wraps explicitly from DEPTH-1 to 0, so non-power-of-two DEPTH works.
- Output: combinational from registered state; no added latency.
  - valid_o = (count != 0).
  - req_o = newest entry (MODE 0) or oldest entry (MODE 1) when valid_o = 1, otherwise 0.
- Duplicate check (DEDUP_EN = 1):
  - val_i is compared against all currently valid entries (pre-edge state).
  - On a hit the push is discarded, dup_o pulses next cycle, and any pop in the same cycle still executes.
  - With DEDUP_EN = 0, dup_o is tied to 0.
- Pop only: ignored when empty. Otherwise count decrements; in MODE 1 head also advances.
- Push only, accepted:
  - Not full: write at the next slot, count increments.
  - Full: overwrite the oldest entry at head, head advances, count stays DEPTH, drop_o pulses next cycle.
- Push and pop in the same cycle, push accepted:
  - Empty: behaves as push only; the pop is ignored.
  - MODE 0, non-empty: overwrite the newest entry; count and head unchanged; no drop.
  - MODE 1, non-empty: the oldest is consumed and the new entry is written at the next slot (the freed slot when full). Head advances, count unchanged, no drop.
- drop_o and dup_o are registered, asserted for exactly one cycle per event, and never both in the same cycle.
- count_o never exceeds DEPTH and never underflows.

Test Plan:
- Reset then idle: after rst_i, hold push_i = pop_i = 0 for 3 cycles -> valid_o = 0, req_o = 0, count_o = 0, full_o = 0, no pulses.
- LIFO fill and overflow (DEPTH = 4, MODE = 0): push 0x10, 0x20, 0x30, 0x40, 0x50 -> after 4 pushes full_o = 1, req_o = 0x40. After the 5th push drop_o pulses once, req_o = 0x50. Popping 4 times yields 0x50, 0x40, 0x30, 0x20, then valid_o = 0.
- FIFO order with wrap (DEPTH = 4, MODE = 1): push 0x1..0x4, pop 2, push 0x5, 0x6 -> req_o sequence on pops is 0x3, 0x4, 0x5, 0x6. count_o = 4 before the pops begin.
- Simultaneous push+pop:
  - MODE 0 with {0xA, 0xB}, push 0xC with pop -> req_o = 0xC, count_o = 2.
  - MODE 1 full {1, 2, 3, 4}, push 5 with pop -> req_o = 2, count_o = 4, drop_o = 0.
  - Empty, push 7 with pop -> count_o = 1, req_o = 7.
- Dedup: with {0x100, 0x200}, push 0x100 -> dup_o pulses, count_o stays 2. Push 0x100 with pop in MODE 0 -> 0x200 popped, push discarded, count_o = 1, req_o = 0x100.
- Control priority: with 3 entries, assert lock_i with push_i and pop_i for 2 cycles -> state unchanged. Then flush_i together with lock_i -> count_o = 0. Then rst_i mid-burst of pushes -> all outputs at reset values the next cycle.
